// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, MSB first, programmable SCLK half-period and chip-select hold
module spi_master #(
    parameter int CLK_DIV = 3,
    parameter int WIDTH   = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             hold_cs_i,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             sclk_o,
    output logic             mosi_o,
    input  logic             miso_i,
    output logic             cs_n_o
);

    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             div_end;

    assign div_end = (div_q == DIV_LAST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            hold_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;

        case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (start_i) begin
                    tx_sh_d = tx_data_i;
                    hold_d  = hold_cs_i;
                    mosi_d  = tx_data_i[WIDTH-1];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP, LOW: begin
                if (div_end) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[WIDTH-2:0], miso_i};
                    state_d = HIGH;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HIGH: begin
                if (div_end) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        // Rotate rather than shift; the wrapped MSB is never presented.
                        bit_d   = bit_q + 1'b1;
                        tx_sh_d = {tx_sh_q[WIDTH-2:0], tx_sh_q[WIDTH-1]};
                        mosi_d  = tx_sh_q[WIDTH-2];
                        state_d = LOW;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_end) begin
                    div_d     = '0;
                    cs_n_d    = ~hold_q;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data_o = rx_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_n_o    = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed plus randomized checks of spi_master at CLK_DIV=3 and CLK_DIV=1
module tb_spi_master;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst   [2];
    logic         start [2];
    logic         hold  [2];
    logic         miso  [2];
    logic [W-1:0] txd   [2];
    logic [W-1:0] rxd   [2];
    logic         busy  [2];
    logic         done  [2];
    logic         sclk  [2];
    logic         mosi  [2];
    logic         csn   [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(3), .WIDTH(W)) u_n3 (
        .clk_i(clk), .reset_i(rst[0]), .start_i(start[0]), .hold_cs_i(hold[0]),
        .tx_data_i(txd[0]), .rx_data_o(rxd[0]), .busy_o(busy[0]), .done_o(done[0]),
        .sclk_o(sclk[0]), .mosi_o(mosi[0]), .miso_i(miso[0]), .cs_n_o(csn[0])
    );

    spi_master #(.CLK_DIV(1), .WIDTH(W)) u_n1 (
        .clk_i(clk), .reset_i(rst[1]), .start_i(start[1]), .hold_cs_i(hold[1]),
        .tx_data_i(txd[1]), .rx_data_o(rxd[1]), .busy_o(busy[1]), .done_o(done[1]),
        .sclk_o(sclk[1]), .mosi_o(mosi[1]), .miso_i(miso[1]), .cs_n_o(csn[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ndiv(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    task automatic check_reset_outputs(input int d, input string tag);
        check({tag, "_outputs"}, {rxd[d], busy[d], done[d], sclk[d], mosi[d], csn[d]},
              {8'h00, 5'b00001});
    endtask

    // One transfer, entered and left just after a falling clk edge. The slave either loops
    // mosi back or returns sbyte MSB first; ign>0 pulses start at that cycle and at the done edge.
    task automatic xfer(input int d, input logic [W-1:0] tx, input logic hold_in,
                        input logic loopback, input logic [W-1:0] sbyte, input int ign);
        int n;
        int lat;
        int rises;
        int last_rise;
        int last_fall;
        int idx;
        logic [W-1:0] exp_rx;
        logic pscl;
        logic stable;
        logic mosi_hi;
        n = ndiv(d);
        lat = (2 * W + 1) * n;
        exp_rx = loopback ? tx : sbyte;
        rises = 0;
        last_rise = 0;
        last_fall = 0;
        pscl = 1'b0;
        stable = 1'b1;
        mosi_hi = 1'b0;
        for (int i = 0; i < 200 && busy[d]; i++) @(negedge clk);
        check("idle_before_start", {31'd0, busy[d]}, 0);
        txd[d] = tx;
        hold[d] = hold_in;
        start[d] = 1'b1;
        miso[d] = sbyte[W-1];
        @(posedge clk);
        @(negedge clk);
        start[d] = 1'b0;
        check("accept_cs_busy_mosi", {busy[d], csn[d], sclk[d], mosi[d]}, {3'b100, tx[W-1]});
        if (loopback) miso[d] = mosi[d];
        for (int cyc = 1; cyc <= lat; cyc++) begin
            if (ign > 0 && cyc == ign + 1) start[d] = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (sclk[d] && !pscl) begin
                idx = W - 1 - rises;
                check("mosi_bit_at_rise", {31'd0, mosi[d]}, {31'd0, tx[idx]});
                check("sclk_rise_spacing", cyc - last_fall, n);
                rises++;
                last_rise = cyc;
                mosi_hi = mosi[d];
            end else if (sclk[d] && pscl) begin
                if (mosi[d] !== mosi_hi) stable = 1'b0;
            end else if (!sclk[d] && pscl) begin
                check("sclk_high_len", cyc - last_rise, n);
                last_fall = cyc;
            end
            pscl = sclk[d];
            if (cyc < lat) begin
                check("in_flight_done_busy_csn", {done[d], busy[d], csn[d]}, 3'b010);
            end else begin
                check("done_busy_at_latency", {done[d], busy[d]}, 2'b10);
                check("rx_data", rxd[d], exp_rx);
                check("csn_after_done", {31'd0, csn[d]}, {31'd0, ~hold_in});
                check("sclk_rise_count", rises, W);
                check("mosi_stable_while_high", {31'd0, stable}, 1);
                check("cs_hold_after_last_fall", cyc - last_fall, n);
                check("mosi_keeps_last_bit", {sclk[d], mosi[d]}, {1'b0, tx[0]});
            end
            if (loopback) miso[d] = mosi[d];
            else if (rises < W) miso[d] = sbyte[W-1-rises];
            if (ign > 0 && cyc == ign) start[d] = 1'b1;
            if (ign > 0 && cyc == lat - 1) start[d] = 1'b1;
        end
        if (ign > 0) begin
            start[d] = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check("ignored_start_stays_idle", {done[d], busy[d]}, 2'b00);
            end
        end
    endtask

    task automatic idle_check(input int d);
        @(negedge clk);
        check("post_done_idle", {done[d], busy[d], csn[d], sclk[d]}, 4'b0010);
    endtask

    task automatic reset_mid(input int d, input int at_cyc);
        txd[d] = 8'h6B;
        hold[d] = 1'b1;
        miso[d] = 1'b1;
        start[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[d] = 1'b0;
        for (int i = 1; i < at_cyc; i++) @(negedge clk);
        check("before_reset_busy", {31'd0, busy[d]}, 1);
        rst[d] = 1'b1;
        #1;
        check_reset_outputs(d, "mid_reset");
        @(negedge clk);
        rst[d] = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("no_done_after_reset", {done[d], busy[d], csn[d]}, 3'b001);
        end
    endtask

    initial begin
        logic [W-1:0] r_tx;
        logic [W-1:0] r_sb;
        logic r_hold;
        logic r_loop;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            start[d] = 1'b0;
            hold[d] = 1'b0;
            miso[d] = 1'b0;
            txd[d] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs(0, "reset_n3");
        check_reset_outputs(1, "reset_n1");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        xfer(0, 8'hA5, 1'b0, 1'b1, 8'h00, 0);
        idle_check(0);
        xfer(0, 8'hFF, 1'b0, 1'b0, 8'h3C, 0);
        idle_check(0);
        xfer(0, 8'h96, 1'b1, 1'b1, 8'h00, 0);
        xfer(0, 8'h4E, 1'b0, 1'b0, 8'hD1, 0);
        idle_check(0);
        xfer(0, 8'h5A, 1'b0, 1'b1, 8'h00, 10);

        for (int i = 0; i < 6; i++) begin
            r_tx = W'($urandom);
            r_sb = W'($urandom);
            r_hold = 1'($urandom);
            r_loop = 1'($urandom);
            xfer(0, r_tx, r_hold, r_loop, r_sb, 0);
            r_tx = W'($urandom);
            r_sb = W'($urandom);
            xfer(1, r_tx, r_hold, r_loop, r_sb, 0);
        end
        xfer(0, 8'h00, 1'b0, 1'b0, 8'hFF, 0);
        idle_check(0);

        xfer(1, 8'h81, 1'b0, 1'b1, 8'h00, 0);
        idle_check(1);
        reset_mid(1, 9);
        xfer(1, 8'hC3, 1'b0, 1'b0, 8'h2D, 0);
        idle_check(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
